// File: rtl/spi_cmd_pkg.sv
// Shared constants for the SPI command decoder: frame geometry, opcodes,
// status word layout and decoder state type.
// Optional build macro: SPI_CMD_ABORT_EN (makes OPC_ABORT a legal opcode).
package spi_cmd_pkg;

  localparam int unsigned FRAME_W  = 136;
  localparam int unsigned OPC_W    = 8;
  localparam int unsigned PAY_W    = FRAME_W - OPC_W;
  localparam int unsigned STATUS_W = 24;

  localparam logic [OPC_W-1:0] OPC_STATUS  = 8'h00;
  localparam logic [OPC_W-1:0] OPC_EXC_DD  = 8'h01;
  localparam logic [OPC_W-1:0] OPC_EXC_XOR = 8'h02;
  localparam logic [OPC_W-1:0] OPC_RD_DD   = 8'h03;
  localparam logic [OPC_W-1:0] OPC_RD_XOR  = 8'h04;
  localparam logic [OPC_W-1:0] OPC_ABORT   = 8'h05;

  // Status word bit positions
  localparam int unsigned STS_ERR_SAT      = 23;
  localparam int unsigned STS_ERR_BUSY     = 22;
  localparam int unsigned STS_ERR_OPC      = 21;
  localparam int unsigned STS_BUSY         = 20;
  localparam int unsigned STS_LAST_OPC_LSB = 8;
  localparam int unsigned STS_CNT_LSB      = 0;

  typedef enum logic [1:0] {
    IDLE,
    EXC_DD,
    EXC_XOR
  } state_t;

  // Assemble the 24-bit status word; bits [19:16] are reserved zero.
  function automatic logic [STATUS_W-1:0] pack_status(
    input logic       err_sat,
    input logic       err_busy,
    input logic       err_opc,
    input logic       busy,
    input logic [7:0] last_opc,
    input logic [7:0] cnt_lo
  );
    logic [STATUS_W-1:0] st;
    st                            = '0;
    st[STS_ERR_SAT]               = err_sat;
    st[STS_ERR_BUSY]              = err_busy;
    st[STS_ERR_OPC]               = err_opc;
    st[STS_BUSY]                  = busy;
    st[STS_LAST_OPC_LSB +: 8]     = last_opc;
    st[STS_CNT_LSB +: 8]          = cnt_lo;
    return st;
  endfunction

endpackage

// File: rtl/spi_cmd_decoder_exc_counter.sv
// Excitation length counter: loads N from the command payload (saturating
// to all-ones when any payload bit above CNT_W is set) and counts down one
// per excite cycle.
module exc_counter #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PAY_W = 128
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic             clear,
  input  logic [PAY_W-1:0] payload,
  output logic             sat,
  output logic             n_zero,
  output logic             at_last,
  output logic [7:0]       count_lo
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] n_val;

  // Requested length with saturation on oversized payloads
  always_comb begin
    sat      = |payload[PAY_W-1:CNT_W];
    n_val    = sat ? '1 : payload[CNT_W-1:0];
    n_zero   = (n_val == '0);
    at_last  = (count == CNT_W'(1));
    count_lo = count[7:0];
  end

  // Down-counter: load on accepted excite, decrement per excite cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= n_val;
    end else if (step && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: decodes received frames into PUF excitation runs,
// response reads and status reads, and produces the reply frame for the
// SPI transmit path.
// Optional build macro: SPI_CMD_ABORT_EN (opcode 0x05 aborts a running
// excitation; without it 0x05 is an unknown opcode).
module spi_cmd_decoder
  import spi_cmd_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [FRAME_W-1:0] RX_DATA,
  input  logic               RX_VALID,
  input  logic [PAY_W-1:0]   DD_RESP,
  input  logic [PAY_W-1:0]   XOR_RESP,
  output logic               DD_EXCITE,
  output logic               XOR_EXCITE,
  output logic               EXC_DONE,
  output logic [FRAME_W-1:0] TX_DATA,
  output logic               TX_LOAD,
  output logic               BUSY
);

  state_t              state;
  logic                err_sat;
  logic                err_busy;
  logic                err_opc;
  logic [OPC_W-1:0]    last_opc;

  logic [OPC_W-1:0]    rx_opc;
  logic [PAY_W-1:0]    rx_payload;
  logic                busy_now;
  logic                accept_exc;
  logic                do_abort;
  logic                cnt_sat;
  logic                cnt_zero;
  logic                cnt_last;
  logic [7:0]          cnt_lo;
  logic [STATUS_W-1:0] status;

  // Frame split, command qualification and live status word
  always_comb begin
    rx_opc     = RX_DATA[FRAME_W-1 -: OPC_W];
    rx_payload = RX_DATA[PAY_W-1:0];
    busy_now   = (state != IDLE);
    accept_exc = RX_VALID && !busy_now &&
                 ((rx_opc == OPC_EXC_DD) || (rx_opc == OPC_EXC_XOR));
`ifdef SPI_CMD_ABORT_EN
    do_abort   = RX_VALID && busy_now && (rx_opc == OPC_ABORT);
`else
    do_abort   = 1'b0;
`endif
    status     = pack_status(err_sat, err_busy, err_opc, BUSY, last_opc, cnt_lo);
  end

  exc_counter #(
    .CNT_W (CNT_W),
    .PAY_W (PAY_W)
  ) u_exc_counter (
    .clk      (CLK),
    .reset    (RESET),
    .load     (accept_exc),
    .step     (busy_now && !do_abort),
    .clear    (do_abort),
    .payload  (rx_payload),
    .sat      (cnt_sat),
    .n_zero   (cnt_zero),
    .at_last  (cnt_last),
    .count_lo (cnt_lo)
  );

  // Decode FSM with registered excite, pulse and reply-frame outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      DD_EXCITE  <= 1'b0;
      XOR_EXCITE <= 1'b0;
      BUSY       <= 1'b0;
      EXC_DONE   <= 1'b0;
      TX_LOAD    <= 1'b0;
      TX_DATA    <= '0;
      err_sat    <= 1'b0;
      err_busy   <= 1'b0;
      err_opc    <= 1'b0;
      last_opc   <= '0;
    end else begin
      EXC_DONE <= 1'b0;
      TX_LOAD  <= 1'b0;

      // Counter at 1 means this is the final excite cycle
      if (busy_now && cnt_last) begin
        state      <= IDLE;
        DD_EXCITE  <= 1'b0;
        XOR_EXCITE <= 1'b0;
        BUSY       <= 1'b0;
        EXC_DONE   <= 1'b1;
      end

      if (RX_VALID) begin
        last_opc <= rx_opc;
        case (rx_opc)
          OPC_STATUS: begin
            // Reported word is the pre-clear snapshot
            TX_DATA  <= {OPC_STATUS, {(PAY_W-STATUS_W){1'b0}}, status};
            TX_LOAD  <= 1'b1;
            err_sat  <= 1'b0;
            err_busy <= 1'b0;
            err_opc  <= 1'b0;
          end
          OPC_EXC_DD, OPC_EXC_XOR: begin
            if (busy_now) begin
              err_busy <= 1'b1;
            end else begin
              if (cnt_sat) begin
                err_sat <= 1'b1;
              end
              if (cnt_zero) begin
                EXC_DONE <= 1'b1;
              end else if (rx_opc == OPC_EXC_DD) begin
                state     <= EXC_DD;
                DD_EXCITE <= 1'b1;
                BUSY      <= 1'b1;
              end else begin
                state      <= EXC_XOR;
                XOR_EXCITE <= 1'b1;
                BUSY       <= 1'b1;
              end
            end
          end
          OPC_RD_DD: begin
            TX_DATA <= {rx_opc, DD_RESP};
            TX_LOAD <= 1'b1;
          end
          OPC_RD_XOR: begin
            TX_DATA <= {rx_opc, XOR_RESP};
            TX_LOAD <= 1'b1;
          end
`ifdef SPI_CMD_ABORT_EN
          OPC_ABORT: begin
            if (busy_now) begin
              state      <= IDLE;
              DD_EXCITE  <= 1'b0;
              XOR_EXCITE <= 1'b0;
              BUSY       <= 1'b0;
              EXC_DONE   <= 1'b1;
            end
          end
`endif
          default: begin
            err_opc <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/spi_cmd_decoder.md
Name: spi_cmd_decoder

Overview:
- Consumes each 136-bit frame produced by the SPI slave receiver: 8-bit opcode in bits [135:128], 128-bit payload in bits [127:0].
- Decodes the opcode to excite the DD-PUF or XOR-PUF for N clock cycles, or to capture a PUF response or status word.
- Hands the reply frame back to the SPI transmit path for the next SSEL transaction.
- Sits between the SPI receiver and the PUF cores inside top_digital_part.

Parameters:
- FRAME_W, 136, total SPI frame width.
- OPC_W, 8, opcode width (frame MSBs).
- CNT_W, 16, excitation counter width; payload bits above CNT_W trigger saturation.

Ports:
- CLK  in  1  system clock (50 MHz).
- RESET  in  1  synchronous, active-high reset.
- RX_DATA  in  FRAME_W  received frame; stable while RX_VALID is high.
- RX_VALID  in  1  single-cycle CLK-domain pulse, one per completed frame.
- DD_RESP  in  128  DD-PUF response.
- XOR_RESP  in  128  XOR-PUF response.
- DD_EXCITE  out  1  DD-PUF excitation enable.
- XOR_EXCITE  out  1  XOR-PUF excitation enable.
- EXC_DONE  out  1  one-cycle pulse after the last excitation cycle.
- TX_DATA  out  FRAME_W  reply frame for the SPI transmitter.
- TX_LOAD  out  1  one-cycle pulse when TX_DATA is updated.
- BUSY  out  1  high while an excitation is in progress.

Behaviour:
- Reset (synchronous, active-high):
  - Outputs: DD_EXCITE, XOR_EXCITE, EXC_DONE, TX_LOAD, BUSY = 0; TX_DATA = 0.
  - State: IDLE; counter = 0; sticky error bits = 0; last_opc = 0.
  - Reset asserted mid-excitation drops both excites on the next edge; no EXC_DONE is issued.
- States: IDLE, EXC_DD, EXC_XOR.
- Opcodes are decoded only on cycles with RX_VALID = 1. RX_VALID at edge t:
  - 0x00 STATUS: at t+1, TX_DATA = {0x00, 104'b0, status[23:0]} and TX_LOAD = 1. Sticky errors clear at t+1; the reported value is the pre-clear value.
  - 0x01 / 0x02 EXCITE:
    - N = payload[CNT_W-1:0]; if any of payload[127:CNT_W] is 1, N = 2^CNT_W - 1 and ERR_SAT is set.
    - N = 0: no excite; EXC_DONE pulses at t+1; state stays IDLE.
    - N > 0: DD_EXCITE (0x01) or XOR_EXCITE (0x02) and BUSY are high for exactly cycles t+1..t+N. EXC_DONE pulses at t+N+1, then state returns to IDLE.
  - 0x03 / 0x04 READ: at t+1, TX_DATA = {opcode, DD_RESP or XOR_RESP sampled at t} and TX_LOAD = 1. Reads are allowed while BUSY; they return the live response.
  - Any other opcode: ERR_OPC set; no other effect; no TX_LOAD.
- EXCITE command while BUSY: ignored; ERR_BUSY set; the running excitation is unaffected.
- DD_EXCITE and XOR_EXCITE are never high in the same cycle.
- TX_DATA holds its value until the next TX_LOAD.
- Counter: loaded with N at t, decrements each excite cycle; exits the excite state when the counter equals 1. No wrap-around is possible.
- status[23:0] = {ERR_SAT, ERR_BUSY, ERR_OPC, BUSY, 4'b0, last_opc[7:0], counter[7:0]}.
  - last_opc is updated on every RX_VALID.

Optional Feature:
- Macro: SPI_CMD_ABORT_EN.
- Defined:
  - Opcode 0x05 ABORT is legal and accepted even while BUSY.
  - Both excites drop at t+1; EXC_DONE pulses at t+1; state returns to IDLE; ERR_BUSY is not set.
  - ABORT in IDLE is a no-op.
- Undefined: 0x05 is an unknown opcode and sets ERR_OPC.

Decomposition:
- Package spi_cmd_pkg holds the shared constants: opcode localparams (OPC_STATUS, OPC_EXC_DD, OPC_EXC_XOR, OPC_RD_DD, OPC_RD_XOR, OPC_ABORT), status bit indices, FRAME_W and OPC_W.
- Sub-module exc_counter (CNT_W down-counter with load, done and saturate logic) is natural.
- Decode FSM and TX mux stay in the top.

Test Plan:
- Reset, then RX {0x01, 128'd10} -> DD_EXCITE high exactly 10 cycles starting t+1; BUSY matches; EXC_DONE at t+11; XOR_EXCITE stays 0.
- RX {0x02, 128'd128}, then RX {0x01, 128'd5} at t+20 -> XOR_EXCITE high 128 cycles, unbroken; DD_EXCITE stays 0; STATUS read afterwards shows ERR_BUSY = 1; a second STATUS read shows 0.
- RX {0x01, 128'd0} -> no excite; EXC_DONE at t+1. Then RX {0x01, 1<<20} -> 65535 excite cycles and ERR_SAT = 1.
- With DD_RESP = 128'hDEAD...BEEF, RX {0x03, 0} -> TX_LOAD at t+1 with TX_DATA = {0x03, DD_RESP}. RX {0x04, 0} -> {0x04, XOR_RESP}.
- RX {0x7F, 0} -> no TX_LOAD, no excite; following STATUS read has ERR_OPC = 1 and last_opc = 0x7F.
- RESET asserted 3 cycles into a 10-cycle excite -> excite low next edge, no EXC_DONE. With SPI_CMD_ABORT_EN defined, 0x05 mid-excite -> excite low and EXC_DONE at t+1.
